ms_ahbl_sram: RTL and testbench
===============================

# ms_ahbl_sram

- AHB-Lite slave SRAM with parameterized wait states and byte/halfword/word write lane merging.
- It is the responder on the far end of the DMA controller's AHB-Lite master port, and the standard scratch/target memory in the subsystem and DMA benches.
- Serves single transfers only: NONSEQ and SEQ are treated identically; no bursts tracking.

## Interface
Parameters:
- AW, 10, log2 of depth in 32-bit words (default 1024 words = 4 KB).
- WAIT_STATES, 0, wait cycles inserted per data phase; legal range 0..7.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; bit 1 set means NONSEQ or SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word.
- HREADY  in  1  bus ready (previous transfer complete).
- HWDATA  in  32  write data (data phase).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1] sampled at a rising edge.
- On accept, register HADDR[AW+1:0], HWRITE and HSIZE as the address-phase capture.
- Word index = addr_q[AW+1:2].
- Lane enables (little-endian):
  - byte: bit addr_q[1:0].
  - half: lanes {addr_q[1],0} and {addr_q[1],1}.
  - word: all four lanes.
  - HSIZE > 2 is treated as word.
- Writes: enabled lanes of HWDATA are merged into the addressed word at the edge that ends the data phase (HREADYOUT = 1). Other lanes are unchanged.
- Reads: HRDATA = mem[word index] combinationally while in the read data phase, and 0 otherwise. The full word is returned regardless of HSIZE.
- FSM states:
  - IDLE: no transfer pending. Accept goes to WAIT if WAIT_STATES > 0, otherwise to DATA.
  - WAIT: HREADYOUT = 0. A 3-bit counter is loaded with WAIT_STATES−1 on accept and decrements each cycle; at 0 go to DATA.
  - DATA: HREADYOUT = 1 and the transfer completes. A new accept in the same cycle (pipelined) re-enters WAIT or DATA; otherwise go to IDLE.
  - ERR1 / ERR2: only exist with the macro (see Configuration).
- IDLE/BUSY transfers and unselected cycles: zero-wait OKAY (HREADYOUT = 1, HRESP = 0); memory untouched.
- Write-then-read to the same word back-to-back: the read returns the newly written data. This needs no forwarding logic, because the write commits before the read's data phase.
- Memory contents are not reset. After power-up, read data is undefined until the word is written.

## Timing
- Reset values: HREADYOUT = 1, HRESP = 0, HRDATA = 0, state = IDLE, wait counter = 0.
- Zero wait: address phase in cycle N, data phase in cycle N+1 with HREADYOUT = 1. The write commits at the end of N+1.
- WAIT_STATES = W: the data phase lasts W+1 cycles, with HREADYOUT low for the first W.
- Back-to-back accepts at W = 0 sustain one transfer per cycle.
- Reset asserted mid-transfer: all outputs immediately take their reset values and any pending write is dropped.

## Configuration
- MS_AHBL_SRAM_ERR_EN defined: an accepted transfer gets an ERROR response if any of these hold:
  - out of range: HADDR[31:AW+2] ≠ 0;
  - misaligned: half with HADDR[0] = 1, or word with HADDR[1:0] ≠ 0;
  - HSIZE > 2.
- ERROR response sequence:
  - It bypasses wait states.
  - ERR1: HREADYOUT = 0, HRESP = 1.
  - ERR2: HREADYOUT = 1, HRESP = 1.
  - Then IDLE, or accept a new transfer.
  - Writes are suppressed. HRDATA = 0.
- Not defined:
  - ERR states are absent and HRESP is tied to 0.
  - Out-of-range addresses alias modulo 2^(AW+2).
  - Misaligned accesses use the lanes computed from the low address bits as described.

## Structure
- Shared package ahbl_pkg holds:
  - HTRANS encodings (IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3);
  - HSIZE encodings (BYTE = 0, HALF = 1, WORD = 2);
  - HRESP values (OKAY = 0, ERROR = 1).
- The FSM state encoding stays local.
- One sub-module: ahbl_lane_decode (addr[1:0], size → 4-bit lane enable), combinational. It is reused by other AHB-Lite slaves.

## Test plan
- W = 0: write word 0x1122_3344 to 0x0000_0010, then read 0x10 → HRDATA = 0x1122_3344 in the cycle after the read address phase, with HREADYOUT held high throughout.
- Byte write 0xAA to 0x11, then half write 0xBBCC to 0x12 over 0x1122_3344 → read of 0x10 returns 0xBBCC_AA44.
- WAIT_STATES = 3: single read → HREADYOUT low for exactly 3 cycles, then high with valid data. Back-to-back pair → 8 cycles total.
- Pipelined write 0xDEAD_BEEF to 0x20 immediately followed by read of 0x20 → read returns 0xDEAD_BEEF.
- With MS_AHBL_SRAM_ERR_EN and AW = 10: write to 0x0000_1000 → HRESP = 1 for 2 cycles, HREADYOUT 0 then 1, memory unchanged. Without the macro, the same write aliases to word 0.
- Assert HRESETn low during a wait state (W = 3) → HREADYOUT = 1 and HRESP = 0 immediately; the pending write is not committed.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings (HTRANS, HSIZE, HRESP) used by all AHB-Lite slaves in the subsystem.
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

endpackage

// File: rtl/ahbl_lane_decode.sv
// Little-endian byte-lane enable decode from address low bits and HSIZE.
// Sizes above word are treated as word.
module ahbl_lane_decode
    import ahbl_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] size,
    output logic [3:0] lane_en
);

    // NOTE: every output of an always_comb gets a value on every path
    // (default first), otherwise synthesis infers a latch.
    always_comb begin
        lane_en = 4'b1111;
        case (size)
            HSIZE_BYTE: lane_en = 4'b0001 << addr;
            HSIZE_HALF: lane_en = addr[1] ? 4'b1100 : 4'b0011;
            default:    lane_en = 4'b1111;
        endcase
    end

endmodule

// File: rtl/ms_ahbl_sram.sv
// AHB-Lite slave SRAM with WAIT_STATES wait cycles and byte/half/word lane merging.
// Define MS_AHBL_SRAM_ERR_EN to add ERROR responses for out-of-range/misaligned/oversize transfers.
module ms_ahbl_sram
    import ahbl_pkg::*;
#(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

`ifdef MS_AHBL_SRAM_ERR_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_e;
`endif

    localparam int         DEPTH   = 1 << AW;
    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES - 1);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic            write_q, write_d;
    logic [2:0]      size_q, size_d;

    logic [31:0]     mem [DEPTH];
    logic            accept;
    logic            mem_we;
    logic [3:0]      lane_en;
    logic [AW-1:0]   word_idx;

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign word_idx = addr_q[AW+1:2];

`ifdef MS_AHBL_SRAM_ERR_EN
    logic req_err;
    assign req_err = (HADDR[31:AW+2] != '0)
                   || ((HSIZE == HSIZE_HALF) && HADDR[0])
                   || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))
                   || (HSIZE > HSIZE_WORD);
`endif

    ahbl_lane_decode u_lane_decode (
        .addr    (addr_q[1:0]),
        .size    (size_q),
        .lane_en (lane_en)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        mem_we  = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_DATA: begin
                mem_we  = write_q;
                state_d = ST_IDLE;
            end
`ifdef MS_AHBL_SRAM_ERR_EN
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase

        // A new address phase overrides the default progression (pipelined accept).
        if (accept) begin
            addr_d  = HADDR[AW+1:0];
            write_d = HWRITE;
            size_d  = HSIZE;
            if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = WS_LOAD;
            end else begin
                state_d = ST_DATA;
            end
`ifdef MS_AHBL_SRAM_ERR_EN
            if (req_err) begin
                state_d = ST_ERR1;
                cnt_d   = 3'd0;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // NOTE: the memory array has no reset so it maps onto SRAM macros; a
    // reset mid-transfer still drops the write because state_q leaves DATA.
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        HRDATA    = '0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        if ((state_q == ST_WAIT || state_q == ST_DATA) && !write_q) HRDATA = mem[word_idx];
        if (state_q == ST_WAIT) HREADYOUT = 1'b0;
`ifdef MS_AHBL_SRAM_ERR_EN
        if (state_q == ST_ERR1) HREADYOUT = 1'b0;
        if (state_q == ST_ERR1 || state_q == ST_ERR2) HRESP = HRESP_ERROR;
`endif
    end

endmodule

// File: tb/tb_ms_ahbl_sram.sv
// Directed bench for ms_ahbl_sram: one instance with no wait states, one with three.
// Covers lane merging, pipelining, wait timing, aliasing/ERROR and reset mid-transfer.
module tb_ms_ahbl_sram;
    import ahbl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel0, hsel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3;
    logic        hresp0, hresp3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ms_ahbl_sram #(.AW(10), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hreadyout0), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
    );

    ms_ahbl_sram #(.AW(10), .WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hreadyout3), .HWDATA(hwdata),
        .HRDATA(hrdata3), .HREADYOUT(hreadyout3), .HRESP(hresp3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One non-pipelined transfer; returns data/response seen when HREADYOUT rises.
    task automatic xfer(input bit use3, input logic [31:0] addr, input bit wr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lows,
                        output logic resp, output logic resp_lo);
        lows    = 0;
        resp_lo = 1'b0;
        if (use3) hsel3 = 1'b1; else hsel0 = 1'b1;
        haddr  = addr;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        hsize  = size;
        @(posedge clk); #1;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = HTRANS_IDLE;
        hwdata = wdata;
        while (!(use3 ? hreadyout3 : hreadyout0) && lows < 20) begin
            resp_lo = use3 ? hresp3 : hresp0;
            lows++;
            @(posedge clk); #1;
        end
        if (lows >= 20) check("xfer_timeout", 32'(lows), 32'd0);
        rdata = use3 ? hrdata3 : hrdata0;
        resp  = use3 ? hresp3 : hresp0;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    int          lows;
    logic        resp, resp_lo;
    int          total, phase;

    initial begin
        rst_n  = 1'b0;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        haddr  = '0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        hwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", 32'(hreadyout0), 32'd1);
        check("rst_resp0",  32'(hresp0),     32'd0);
        check("rst_rdata0", hrdata0,         32'd0);
        check("rst_ready3", 32'(hreadyout3), 32'd1);
        check("rst_resp3",  32'(hresp3),     32'd0);
        check("rst_rdata3", hrdata3,         32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait word write and read-back.
        xfer(0, 32'h10, 1, HSIZE_WORD, 32'h1122_3344, rd, lows, resp, resp_lo);
        check("w0_wr_lows", 32'(lows), 32'd0);
        check("w0_wr_resp", 32'(resp), 32'd0);
        xfer(0, 32'h10, 0, HSIZE_WORD, 32'h0, rd, lows, resp, resp_lo);
        check("w0_rd_lows", 32'(lows), 32'd0);
        check("w0_rd_data", rd, 32'h1122_3344);

        // Byte then half merge over the same word.
        xfer(0, 32'h11, 1, HSIZE_BYTE, 32'h0000_AA00, rd, lows, resp, resp_lo);
        xfer(0, 32'h12, 1, HSIZE_HALF, 32'hBBCC_0000, rd, lows, resp, resp_lo);
        xfer(0, 32'h10, 0, HSIZE_WORD, 32'h0, rd, lows, resp, resp_lo);
        check("merge_data", rd, 32'hBBCC_AA44);

        // Pipelined write then read of the same word.
        hsel0 = 1'b1; haddr = 32'h20; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        hwdata = 32'hDEAD_BEEF;
        hwrite = 1'b0;
        check("pipe_wr_ready", 32'(hreadyout0), 32'd1);
        @(posedge clk); #1;
        hsel0 = 1'b0; htrans = HTRANS_IDLE;
        check("pipe_rd_ready", 32'(hreadyout0), 32'd1);
        check("pipe_rd_data", hrdata0, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Out-of-range write 0x1000 with AW=10.
        xfer(0, 32'h0, 1, HSIZE_WORD, 32'h0BAD_F00D, rd, lows, resp, resp_lo);
        xfer(0, 32'h1000, 1, HSIZE_WORD, 32'h5566_7788, rd, lows, resp, resp_lo);
`ifdef MS_AHBL_SRAM_ERR_EN
        check("err_lows",    32'(lows),    32'd1);
        check("err_resp_lo", 32'(resp_lo), 32'd1);
        check("err_resp_hi", 32'(resp),    32'd1);
        xfer(0, 32'h0, 0, HSIZE_WORD, 32'h0, rd, lows, resp, resp_lo);
        check("err_mem_kept", rd, 32'h0BAD_F00D);
`else
        check("alias_lows", 32'(lows), 32'd0);
        check("alias_resp", 32'(resp), 32'd0);
        xfer(0, 32'h0, 0, HSIZE_WORD, 32'h0, rd, lows, resp, resp_lo);
        check("alias_data", rd, 32'h5566_7788);
`endif

        // Three wait states: single writes and read.
        xfer(1, 32'h40, 1, HSIZE_WORD, 32'hA5A5_0001, rd, lows, resp, resp_lo);
        check("w3_wr_lows", 32'(lows), 32'd3);
        xfer(1, 32'h44, 1, HSIZE_WORD, 32'h5A5A_0002, rd, lows, resp, resp_lo);
        xfer(1, 32'h40, 0, HSIZE_WORD, 32'h0, rd, lows, resp, resp_lo);
        check("w3_rd_lows", 32'(lows), 32'd3);
        check("w3_rd_data", rd, 32'hA5A5_0001);
        check("w3_rd_resp", 32'(resp), 32'd0);

        // Back-to-back pair: 8 data-phase cycles in total.
        hsel3 = 1'b1; haddr = 32'h40; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        hsel3 = 1'b0; htrans = HTRANS_IDLE;
        total = 0;
        phase = 0;
        while (phase < 2 && total < 40) begin
            total++;
            if (hreadyout3) begin
                if (phase == 0) begin
                    check("pair_rd0", hrdata3, 32'hA5A5_0001);
                    hsel3 = 1'b1; haddr = 32'h44; htrans = HTRANS_NONSEQ;
                end else begin
                    check("pair_rd1", hrdata3, 32'h5A5A_0002);
                end
                phase++;
            end
            @(posedge clk); #1;
            hsel3 = 1'b0; htrans = HTRANS_IDLE;
        end
        check("pair_cycles", 32'(total), 32'd8);

        // Reset during a wait state drops the pending write.
        xfer(1, 32'h30, 1, HSIZE_WORD, 32'h1234_5678, rd, lows, resp, resp_lo);
        hsel3 = 1'b1; haddr = 32'h30; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        hsel3 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hCAFE_F00D;
        check("rst_mid_wait", 32'(hreadyout3), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(hreadyout3), 32'd1);
        check("rst_mid_resp",  32'(hresp3),     32'd0);
        check("rst_mid_rdata", hrdata3,         32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 32'h30, 0, HSIZE_WORD, 32'h0, rd, lows, resp, resp_lo);
        check("rst_no_commit", rd, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
